sat_bin_loader: RTL and testbench

- Upstream feeder for sat_bin.
- Accepts a load configuration (bin count, variable count) and a ready/valid word stream from the host/DMA side.
- Writes clause words, then variable words, into sat_bin's clause and var BRAMs through its external write ports (apply, we, din, addr).
- Then pulses start with bin info, waits for done, and latches the sat/unsat verdict for the host.

---
 rtl/sat_bin_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_sat_bin_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_bin_loader.sv
// sat_bin_loader: streams clause and variable words into sat_bin's BRAMs, starts the solve and latches the verdict.
// Optional input-word checking is enabled by defining SAT_BIN_LOADER_CHECK_EN.
`default_nettype none

module sat_bin_loader #(
  parameter int NUM_CLAUSES_A_BIN  = 8,
  parameter int NUM_VARS_A_BIN     = 8,
  parameter int WIDTH_CLAUSES      = 16,
  parameter int WIDTH_VAR          = 12,
  parameter int ADDR_WIDTH_CLAUSES = 9,
  parameter int ADDR_WIDTH_VAR     = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [WIDTH_CLAUSES-1:0]      cfg_nb_i,
  input  logic [WIDTH_VAR-1:0]          cfg_nv_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [WIDTH_CLAUSES-1:0]      s_data_i,
  input  logic                          abort_i,
  output logic                          apply_ex_o,
  output logic                          ram_we_c_ex_o,
  output logic [WIDTH_CLAUSES-1:0]      ram_din_c_ex_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_ex_o,
  output logic                          ram_we_v_ex_o,
  output logic [WIDTH_VAR-1:0]          ram_din_v_ex_o,
  output logic [ADDR_WIDTH_VAR-1:0]     ram_addr_v_ex_o,
  output logic                          start_o,
  output logic                          bin_info_en_o,
  output logic [WIDTH_CLAUSES-1:0]      nb_all_o,
  output logic [WIDTH_VAR-1:0]          nv_all_o,
  input  logic                          done_i,
  input  logic                          global_sat_i,
  input  logic                          global_unsat_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          sat_o,
  output logic                          unsat_o,
  output logic                          err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_C = 3'd1,
    S_LOAD_V = 3'd2,
    S_FLUSH  = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  localparam int PW_C = WIDTH_CLAUSES + ADDR_WIDTH_CLAUSES;
  localparam int PW_V = WIDTH_CLAUSES + ADDR_WIDTH_VAR;
  localparam logic [PW_C-1:0] LIM_C = PW_C'((64'd1 << ADDR_WIDTH_CLAUSES) - 64'd1);
  localparam logic [PW_V-1:0] LIM_V = PW_V'((64'd1 << ADDR_WIDTH_VAR) - 64'd1);

  state_t state, state_nx;

  logic [WIDTH_CLAUSES-1:0]      nb_q;
  logic [WIDTH_VAR-1:0]          nv_q;
  logic [ADDR_WIDTH_CLAUSES-1:0] tot_c;
  logic [ADDR_WIDTH_VAR-1:0]     tot_v;
  logic                          we_c, we_v;
  logic [WIDTH_CLAUSES-1:0]      din_c;
  logic [WIDTH_VAR-1:0]          din_v;
  logic [ADDR_WIDTH_CLAUSES-1:0] addr_c;
  logic [ADDR_WIDTH_VAR-1:0]     addr_v;
  logic                          sat_q, unsat_q, err_q;
  logic                          abort_done;

  logic [PW_C-1:0] prod_c;
  logic [PW_V-1:0] prod_v;
  logic            cfg_bad;
  logic            cfg_take;
  logic            hs;
  logic            abort_take;
  logic [ADDR_WIDTH_CLAUSES-1:0] addr_c_inc;
  logic [ADDR_WIDTH_VAR-1:0]     addr_v_inc;

  // Products are formed wide enough that an oversized bin count can never wrap into range.
  assign prod_c  = PW_C'(cfg_nb_i) * PW_C'(NUM_CLAUSES_A_BIN);
  assign prod_v  = PW_V'(cfg_nb_i) * PW_V'(NUM_VARS_A_BIN);
  assign cfg_bad = (cfg_nb_i == '0) | (prod_c > LIM_C) | (prod_v > LIM_V);

  assign cfg_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign s_ready_o   = (state == S_LOAD_C) | (state == S_LOAD_V);
  assign apply_ex_o  = (state == S_LOAD_C) | (state == S_LOAD_V) | (state == S_FLUSH);
  assign start_o     = (state == S_START);
  assign bin_info_en_o = (state == S_START);
  assign nb_all_o    = (state == S_START) ? nb_q : '0;
  assign nv_all_o    = (state == S_START) ? nv_q : '0;
  assign done_o      = (state == S_FIN) | abort_done;

  assign ram_we_c_ex_o   = we_c;
  assign ram_din_c_ex_o  = din_c;
  assign ram_addr_c_ex_o = addr_c;
  assign ram_we_v_ex_o   = we_v;
  assign ram_din_v_ex_o  = din_v;
  assign ram_addr_v_ex_o = addr_v;
  assign sat_o   = sat_q;
  assign unsat_o = unsat_q;
  assign err_o   = err_q;

  assign cfg_take   = cfg_valid_i & (state == S_IDLE);
  assign hs         = s_valid_i & s_ready_o;
  assign abort_take = abort_i & (state != S_IDLE);
  assign addr_c_inc = addr_c + ADDR_WIDTH_CLAUSES'(1);
  assign addr_v_inc = addr_v + ADDR_WIDTH_VAR'(1);

`ifdef SAT_BIN_LOADER_CHECK_EN
  logic chk_err;
  logic lit_bad;
  logic var_bad;

  always_comb begin
    lit_bad = 1'b0;
    for (int i = 0; i < WIDTH_CLAUSES / 2; i++) begin
      if (s_data_i[2*i +: 2] == 2'b11) lit_bad = 1'b1;
    end
  end

  assign var_bad = (s_data_i[WIDTH_VAR-1:0] > nv_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort_take) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (cfg_valid_i) state_nx = cfg_bad ? S_FIN : S_LOAD_C;
        S_LOAD_C: if (hs && addr_c_inc == tot_c) state_nx = S_LOAD_V;
        S_LOAD_V: if (hs && addr_v_inc == tot_v) state_nx = S_FLUSH;
`ifdef SAT_BIN_LOADER_CHECK_EN
        S_FLUSH:  state_nx = chk_err ? S_FIN : S_START;
`else
        S_FLUSH:  state_nx = S_START;
`endif
        S_START:  state_nx = S_WAIT;
        S_WAIT:   if (done_i) state_nx = S_FIN;
        S_FIN:    state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Write port registers give exactly one cycle from handshake to BRAM write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nb_q       <= '0;
      nv_q       <= '0;
      tot_c      <= '0;
      tot_v      <= '0;
      we_c       <= 1'b0;
      we_v       <= 1'b0;
      din_c      <= '0;
      din_v      <= '0;
      addr_c     <= '0;
      addr_v     <= '0;
      sat_q      <= 1'b0;
      unsat_q    <= 1'b0;
      err_q      <= 1'b0;
      abort_done <= 1'b0;
    end else begin
      we_c       <= 1'b0;
      we_v       <= 1'b0;
      abort_done <= 1'b0;
      if (abort_take) begin
        err_q      <= 1'b1;
        abort_done <= (state != S_FIN);
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_take) begin
              nb_q    <= cfg_nb_i;
              nv_q    <= cfg_nv_i;
              tot_c   <= prod_c[ADDR_WIDTH_CLAUSES-1:0];
              tot_v   <= prod_v[ADDR_WIDTH_VAR-1:0];
              addr_c  <= '0;
              addr_v  <= '0;
              sat_q   <= 1'b0;
              unsat_q <= 1'b0;
              err_q   <= cfg_bad;
            end
          end
          S_LOAD_C: begin
            if (hs) begin
              we_c   <= 1'b1;
              din_c  <= s_data_i;
              addr_c <= addr_c_inc;
`ifdef SAT_BIN_LOADER_CHECK_EN
              if (lit_bad) err_q <= 1'b1;
`endif
            end
          end
          S_LOAD_V: begin
            if (hs) begin
              we_v   <= 1'b1;
              din_v  <= s_data_i[WIDTH_VAR-1:0];
              addr_v <= addr_v_inc;
`ifdef SAT_BIN_LOADER_CHECK_EN
              if (var_bad) err_q <= 1'b1;
`endif
            end
          end
          S_WAIT: begin
            if (done_i) begin
              sat_q   <= global_sat_i;
              unsat_q <= global_unsat_i;
              if (global_sat_i && global_unsat_i) err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SAT_BIN_LOADER_CHECK_EN
  // Violations only redirect the FSM after the load; the offending word is still written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_err <= 1'b0;
    end else if (cfg_take) begin
      chk_err <= 1'b0;
    end else if (!abort_take && hs) begin
      if ((state == S_LOAD_C && lit_bad) || (state == S_LOAD_V && var_bad)) chk_err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sat_bin_loader.sv
// tb_sat_bin_loader: directed + randomized self-checking bench for sat_bin_loader.
`default_nettype none

module tb_sat_bin_loader;

  localparam int NCB = 8;
  localparam int NVB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_nb = '0;
  logic [11:0] cfg_nv = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        abort = 1'b0;
  logic        apply;
  logic        we_c, we_v;
  logic [15:0] din_c;
  logic [8:0]  addr_c;
  logic [11:0] din_v;
  logic [8:0]  addr_v;
  logic        start, bin_en;
  logic [15:0] nb_all;
  logic [11:0] nv_all;
  logic        done_in = 1'b0, gsat = 1'b0, gunsat = 1'b0;
  logic        busy, done_out, sat, unsat, err;

  sat_bin_loader dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_nb_i(cfg_nb), .cfg_nv_i(cfg_nv),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .abort_i(abort),
    .apply_ex_o(apply),
    .ram_we_c_ex_o(we_c), .ram_din_c_ex_o(din_c), .ram_addr_c_ex_o(addr_c),
    .ram_we_v_ex_o(we_v), .ram_din_v_ex_o(din_v), .ram_addr_v_ex_o(addr_v),
    .start_o(start), .bin_info_en_o(bin_en), .nb_all_o(nb_all), .nv_all_o(nv_all),
    .done_i(done_in), .global_sat_i(gsat), .global_unsat_i(gunsat),
    .busy_o(busy), .done_o(done_out), .sat_o(sat), .unsat_o(unsat), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write streams and event counters, sampled mid-cycle.
  int cw_a[$], cw_d[$], vw_a[$], vw_d[$];
  int start_cnt, done_cnt, done_cyc, lat_bad, leak_bad, nb_seen, nv_seen;
  logic prev_hs = 1'b0, prev_abort = 1'b0;
  logic [15:0] stim[$];

  always @(negedge clk) begin
    if (!rst) begin
      prev_hs = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (we_c) begin cw_a.push_back(int'(addr_c)); cw_d.push_back(int'(din_c)); end
      if (we_v) begin vw_a.push_back(int'(addr_v)); vw_d.push_back(int'(din_v)); end
      if ((we_c | we_v) !== (prev_hs & ~prev_abort)) lat_bad++;
      if ((we_c | we_v) & ~apply) lat_bad++;
      if (we_c & we_v) lat_bad++;
      if (start) begin start_cnt++; nb_seen = int'(nb_all); nv_seen = int'(nv_all); end
      if (start !== bin_en) leak_bad++;
      if (!start && (nb_all != '0 || nv_all != '0)) leak_bad++;
      if (done_out) begin done_cnt++; done_cyc = cyc; end
      prev_hs = s_valid & s_ready;
      prev_abort = abort;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cw_a.delete(); cw_d.delete(); vw_a.delete(); vw_d.delete();
    start_cnt = 0; done_cnt = 0; done_cyc = -1; lat_bad = 0; leak_bad = 0;
    nb_seen = -1; nv_seen = -1;
  endtask

  function automatic logic [15:0] rand_clause();
    logic [15:0] w;
    int unsigned r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 2);
      w[2*i +: 2] = r[1:0];
    end
    return w;
  endfunction

  // Clause words use only legal literal codes; var ids stay within [0, nv].
  task automatic build_stim(input int nb, input int nv);
    logic [15:0] w;
    stim.delete();
    for (int k = 0; k < nb * NCB; k++) stim.push_back(rand_clause());
    for (int k = 0; k < nb * NVB; k++) begin
      w = {4'($urandom), 12'($urandom_range(0, nv))};
      stim.push_back(w);
    end
  endtask

  task automatic do_cfg(input int nb, input int nv, output int acc_cyc);
    for (int i = 0; i < 20 && !cfg_ready; i++) begin @(posedge clk); #1; end
    chk("cfg_ready_before_cfg", cfg_ready, 1);
    cfg_nb = 16'(nb); cfg_nv = 12'(nv); cfg_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cfg_valid = 1'b0;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
  task automatic stream(input int mode, input int stop_after, output int sent);
    int c;
    logic v, acc;
    sent = 0; c = 0;
    while (sent < stop_after && c < 4 * stop_after + 50) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      s_valid = v;
      s_data = v ? stim[sent] : 16'($urandom);
      @(negedge clk);
      acc = v & s_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      c++;
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_run(input logic gs, input logic gu);
    for (int i = 0; i < 20 && start_cnt == 0; i++) begin @(posedge clk); #1; end
    done_in = 1'b1; gsat = gs; gunsat = gu;
    @(posedge clk); #1;
    done_in = 1'b0; gsat = 1'b0; gunsat = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_writes(input string tag, input int nb);
    int nc, nv;
    nc = nb * NCB; nv = nb * NVB;
    chk({tag, "_nclause"}, cw_a.size(), nc);
    chk({tag, "_nvar"}, vw_a.size(), nv);
    for (int k = 0; k < nc && k < cw_a.size(); k++) begin
      chk({tag, "_caddr"}, cw_a[k], k + 1);
      chk({tag, "_cdata"}, cw_d[k], int'(stim[k]));
    end
    for (int k = 0; k < nv && k < vw_a.size(); k++) begin
      chk({tag, "_vaddr"}, vw_a[k], k + 1);
      chk({tag, "_vdata"}, vw_d[k], int'(stim[nc + k][11:0]));
    end
    chk({tag, "_latency"}, lat_bad, 0);
    chk({tag, "_bininfo"}, leak_bad, 0);
  endtask

  task automatic full_load(input int nb, input int nv, input int mode, input logic gs,
                           input logic gu, input string tag);
    int acc, sent;
    clear_mon();
    build_stim(nb, nv);
    do_cfg(nb, nv, acc);
    stream(mode, 2 * nb * NCB, sent);
    chk({tag, "_sent"}, sent, 2 * nb * NCB);
    finish_run(gs, gu);
    check_writes(tag, nb);
    chk({tag, "_starts"}, start_cnt, 1);
    chk({tag, "_nb_all"}, nb_seen, nb);
    chk({tag, "_nv_all"}, nv_seen, nv);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_sat"}, sat, gs);
    chk({tag, "_unsat"}, unsat, gu);
    chk({tag, "_err"}, err, gs & gu);
    chk({tag, "_idle"}, {busy, cfg_ready}, 2'b01);
  endtask

  task automatic err_cfg(input int nb, input string tag);
    int acc;
    clear_mon();
    do_cfg(nb, 5, acc);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_done_cyc"}, done_cyc, acc);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_writes"}, cw_a.size() + vw_a.size(), 0);
    chk({tag, "_starts"}, start_cnt, 0);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_ready"}, cfg_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, sent;
    #12;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_outputs", {busy, apply, s_ready, we_c, we_v, start, bin_en, done_out, sat, unsat, err}, 0);
    chk("rst_bus", {nb_all, nv_all, addr_c, addr_v}, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    full_load(2, 10, 0, 1'b1, 1'b0, "cont");
    full_load(2, 10, 1, 1'b0, 1'b1, "toggle");
    err_cfg(0, "nb0");
    err_cfg(64, "nb64");
    full_load(63, int'($urandom_range(1, 4095)), 2, 1'b1, 1'b1, "nb63");
    for (int i = 0; i < 3; i++)
      full_load(int'($urandom_range(1, 4)), int'($urandom_range(1, 4095)),
                int'($urandom_range(0, 2)), 1'($urandom), 1'b0, "rand");

    // Abort after five clause words.
    clear_mon();
    build_stim(2, 5);
    do_cfg(2, 5, acc);
    stream(0, 5, sent);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_apply", apply, 0);
    chk("abort_ready", cfg_ready, 1);
    chk("abort_err", err, 1);
    chk("abort_done_now", done_out, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_writes", cw_a.size(), 5);
    chk("abort_last_addr", (cw_a.size() > 0) ? cw_a[cw_a.size() - 1] : -1, 5);
    chk("abort_done", done_cnt, 1);
    chk("abort_latency", lat_bad, 0);
    chk("abort_starts", start_cnt, 0);

    // Asynchronous reset in the middle of the var phase.
    clear_mon();
    build_stim(1, 7);
    do_cfg(1, 7, acc);
    stream(0, 11, sent);
    #2; rst = 1'b0; #1;
    chk("arst_outputs", {busy, apply, s_ready, we_c, we_v, start, done_out, err}, 0);
    chk("arst_ready", cfg_ready, 1);
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    full_load(1, 7, 0, 1'b0, 1'b0, "after_rst");

    // Illegal literal code in the first clause word.
    clear_mon();
    build_stim(1, 3);
    stim[0] = 16'h0003;
    do_cfg(1, 3, acc);
    stream(0, 16, sent);
`ifdef SAT_BIN_LOADER_CHECK_EN
    repeat (5) begin @(posedge clk); #1; end
    chk("chk_starts", start_cnt, 0);
    chk("chk_err", err, 1);
    chk("chk_done", done_cnt, 1);
`else
    finish_run(1'b1, 1'b0);
    chk("chk_starts", start_cnt, 1);
    chk("chk_err", err, 0);
    chk("chk_sat", sat, 1);
`endif
    chk("chk_first_addr", (cw_a.size() > 0) ? cw_a[0] : -1, 1);
    chk("chk_first_data", (cw_d.size() > 0) ? cw_d[0] : -1, 3);
    chk("chk_nclause", cw_a.size(), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
